// File: rtl/fb_line_scaler_if.sv
// Signal bundle for fb_line_scaler: video-driver requests, framebuffer reads and palette writes.
// master = the side driving requests/RAM data/palette; slave = the scaler itself.
interface fb_line_scaler_if #(
    parameter int ADDR_W = 15
);
    // Handshakes are fixed-latency, no back-pressure: pixel_data answers the data_req of the
    // previous cycle, and fb_rdata answers the fb_rd/fb_addr of the previous cycle.
    logic              frame_sync;
    logic              data_req;
    logic [23:0]       pixel_data;
    logic              almost_empty;
    logic              underrun;
    logic              fb_rd;
    logic [ADDR_W-1:0] fb_addr;
    logic [3:0]        fb_rdata;
    logic              pal_we;
    logic [3:0]        pal_idx;
    logic [23:0]       pal_data;
    logic [1:0]        dbg_state;

    modport master (
        output frame_sync, data_req, fb_rdata, pal_we, pal_idx, pal_data,
        input  pixel_data, almost_empty, underrun, fb_rd, fb_addr, dbg_state
    );

    modport slave (
        input  frame_sync, data_req, fb_rdata, pal_we, pal_idx, pal_data,
        output pixel_data, almost_empty, underrun, fb_rd, fb_addr, dbg_state
    );
endinterface

// File: rtl/fb_line_scaler.sv
// Fetches indexed framebuffer lines through a palette into a ping-pong line buffer and serves
// a 2^SCALE_LOG2 upscaled RGB stream. Optional macro FB_SCANLINE_EN dims the last row of each group.
module fb_line_scaler #(
    parameter int          SRC_W        = 160,
    parameter int          SRC_H        = 120,
    parameter int          SCALE_LOG2   = 2,
    parameter int          ADDR_W       = 15,
    parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
    input logic              clk_pixel,
    input logic              reset,
    fb_line_scaler_if.slave  bus
);
    localparam int OUT_W = SRC_W << SCALE_LOG2;
    localparam int OUT_H = SRC_H << SCALE_LOG2;
    localparam int OX_W  = $clog2(OUT_W);
    localparam int OY_W  = $clog2(OUT_H);
    localparam int FX_W  = OX_W - SCALE_LOG2;
    localparam int SL_W  = OY_W - SCALE_LOG2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [OX_W-1:0]   ox_q, ox_d;
    logic [OY_W-1:0]   oy_q, oy_d;
    logic [1:0]        state_q, state_d;
    logic [FX_W-1:0]   fx_q, fx_d;
    logic              fbank_q, fbank_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [1:0]        valid_q, valid_d;
    logic              cap_en_q, cap_en_d;
    logic [FX_W-1:0]   cap_idx_q, cap_idx_d;
    logic              cap_bank_q, cap_bank_d;
    logic [23:0]       pixel_q, pixel_d;
    logic              almost_empty_q, almost_empty_d;
    logic              underrun_q, underrun_d;
    logic [23:0]       palette_q [16];
    logic [23:0]       palette_d [16];
    logic [23:0]       linebuf_q [2][SRC_W];
    logic [23:0]       linebuf_d [2][SRC_W];

    logic              advance;
    logic              row_start;
    logic [FX_W-1:0]   sx;
    logic [SL_W-1:0]   sl;
    logic              disp_bank;
    logic [23:0]       rgb;

    assign sx        = ox_q[OX_W-1:SCALE_LOG2];
    assign sl        = oy_q[OY_W-1:SCALE_LOG2];
    assign disp_bank = sl[0];

    always_comb begin
        // A request coinciding with frame_sync is dropped entirely.
        advance   = bus.data_req & ~bus.frame_sync;
        row_start = advance && (ox_q == '0) && (oy_q[SCALE_LOG2-1:0] == '0)
                    && (sl < SL_W'(SRC_H - 1));

        ox_d = ox_q;
        oy_d = oy_q;
        if (bus.frame_sync) begin
            ox_d = '0;
            oy_d = '0;
        end else if (advance) begin
            if (ox_q == OX_W'(OUT_W - 1)) begin
                ox_d = '0;
                oy_d = (oy_q == OY_W'(OUT_H - 1)) ? '0 : oy_q + 1'b1;
            end else begin
                ox_d = ox_q + 1'b1;
            end
        end

        rgb = linebuf_q[disp_bank][sx];
`ifdef FB_SCANLINE_EN
        if (&oy_q[SCALE_LOG2-1:0]) begin
            rgb = {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
        end
`endif
        pixel_d    = '0;
        underrun_d = underrun_q;
        if (advance) begin
            if (valid_q[disp_bank]) begin
                pixel_d = rgb;
            end else begin
                pixel_d    = UNDERRUN_RGB;
                underrun_d = 1'b1;
            end
        end
        almost_empty_d = ~valid_q[disp_bank];

        state_d     = state_q;
        fx_d        = fx_q;
        fbank_d     = fbank_q;
        line_base_d = line_base_q;
        valid_d     = valid_q;
        cap_en_d    = (state_q == ST_FETCH);
        cap_idx_d   = fx_q;
        cap_bank_d  = fbank_q;
        if (bus.frame_sync) begin
            state_d     = ST_FETCH;
            fx_d        = '0;
            fbank_d     = 1'b0;
            line_base_d = '0;
            valid_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (row_start) begin
                        state_d           = ST_FETCH;
                        fx_d              = '0;
                        fbank_d           = ~sl[0];
                        valid_d[~sl[0]]   = 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (fx_q == FX_W'(SRC_W - 1)) state_d = ST_DRAIN;
                    else                          fx_d    = fx_q + 1'b1;
                end
                ST_DRAIN: begin
                    // Last word lands this cycle; base steps to the next source line.
                    valid_d[fbank_q] = 1'b1;
                    line_base_d      = line_base_q + ADDR_W'(SRC_W);
                    fx_d             = '0;
                    state_d          = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        palette_d = palette_q;
        if (bus.pal_we) palette_d[bus.pal_idx] = bus.pal_data;
        linebuf_d = linebuf_q;
        if (cap_en_q) linebuf_d[cap_bank_q][cap_idx_q] = palette_q[bus.fb_rdata];
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            ox_q           <= '0;
            oy_q           <= '0;
            state_q        <= ST_IDLE;
            fx_q           <= '0;
            fbank_q        <= 1'b0;
            line_base_q    <= '0;
            valid_q        <= '0;
            cap_en_q       <= 1'b0;
            cap_idx_q      <= '0;
            cap_bank_q     <= 1'b0;
            pixel_q        <= '0;
            almost_empty_q <= 1'b1;
            underrun_q     <= 1'b0;
            palette_q      <= '{default: '0};
        end else begin
            ox_q           <= ox_d;
            oy_q           <= oy_d;
            state_q        <= state_d;
            fx_q           <= fx_d;
            fbank_q        <= fbank_d;
            line_base_q    <= line_base_d;
            valid_q        <= valid_d;
            cap_en_q       <= cap_en_d;
            cap_idx_q      <= cap_idx_d;
            cap_bank_q     <= cap_bank_d;
            pixel_q        <= pixel_d;
            almost_empty_q <= almost_empty_d;
            underrun_q     <= underrun_d;
            palette_q      <= palette_d;
        end
    end

    always_ff @(posedge clk_pixel) begin
        linebuf_q <= linebuf_d;
    end

    assign bus.pixel_data   = pixel_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.underrun     = underrun_q;
    assign bus.fb_rd        = (state_q == ST_FETCH);
    assign bus.fb_addr      = line_base_q + ADDR_W'(fx_q);
    assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_fb_line_scaler.sv
// Randomized bench for fb_line_scaler against a coordinate-level model of the scaled frame.
// A reduced source height keeps full frames short; line width stays at 160.
module tb_fb_line_scaler;
    localparam int TB_W      = 160;
    localparam int TB_H      = 12;
    localparam int SCALE     = 4;
    localparam int OUT_W     = TB_W * SCALE;
    localparam int OUT_H     = TB_H * SCALE;
    localparam int LAST_ADDR = TB_W * TB_H - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    fb_line_scaler_if #(.ADDR_W(15)) bus();

    fb_line_scaler #(
        .SRC_W(TB_W), .SRC_H(TB_H), .SCALE_LOG2(2), .ADDR_W(15), .UNDERRUN_RGB(24'hFF00FF)
    ) dut (
        .clk_pixel(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [3:0]  fb_m  [TB_W*TB_H];
    logic [23:0] pal_m [16];
    logic [23:0] exp_q [$];
    int          n_checks  = 0;
    int          n_errors  = 0;
    int          m_ox      = 0;
    int          m_oy      = 0;
    int          fetch_cnt = 0;
    int          last_hits = 0;
    bit          mon_en    = 1'b0;
    logic        pend      = 1'b0;
    logic        rd_prev   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] model_pix(input int x, input int y);
        logic [23:0] c;
        c = pal_m[fb_m[(y / SCALE) * TB_W + x / SCALE]];
`ifdef FB_SCANLINE_EN
        if (y % SCALE == SCALE - 1) c = (c >> 1) & 24'h7F7F7F;
`endif
        return c;
    endfunction

    // Framebuffer RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.fb_rd === 1'b1) bus.fb_rdata <= fb_m[bus.fb_addr];
        pend <= bus.data_req && !bus.frame_sync && !reset;
    end

    always @(negedge clk) begin
        logic [23:0] e;
        if (mon_en) begin
            if (pend) begin
                if (exp_q.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("pixel", {8'h0, bus.pixel_data}, {8'h0, e});
                end
            end else begin
                chk("pixel_idle", {8'h0, bus.pixel_data}, 32'h0);
            end
        end
        if (bus.fb_rd === 1'b1 && rd_prev !== 1'b1) fetch_cnt++;
        if (bus.fb_rd === 1'b1 && bus.fb_addr == 15'(LAST_ADDR)) last_hits++;
        rd_prev = bus.fb_rd;
    end

    task automatic drive_now(input bit req, input bit fs);
        bus.data_req   = req;
        bus.frame_sync = fs;
        if (fs) begin
            m_ox = 0;
            m_oy = 0;
        end else if (req) begin
            exp_q.push_back(model_pix(m_ox, m_oy));
            if (m_ox == OUT_W - 1) begin
                m_ox = 0;
                m_oy = (m_oy == OUT_H - 1) ? 0 : m_oy + 1;
            end else begin
                m_ox++;
            end
        end
    endtask

    task automatic cycle(input bit req, input bit fs);
        @(negedge clk);
        drive_now(req, fs);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    task automatic pal_write(input int idx, input logic [23:0] d);
        @(negedge clk);
        bus.pal_we   = 1'b1;
        bus.pal_idx  = 4'(idx);
        bus.pal_data = d;
        pal_m[idx]   = d;
        @(negedge clk);
        bus.pal_we = 1'b0;
    endtask

    task automatic start_frame();
        cycle(1'($urandom_range(0, 1)), 1'b1);
        idle(TB_W + 4);
    endtask

    task automatic run_rows(input int n, input bit holes, input int max_gap);
        for (int r = 0; r < n; r++) begin
            int cnt;
            cnt = 0;
            while (cnt < OUT_W) begin
                bit req;
                @(negedge clk);
                req = holes ? ($urandom_range(0, 7) != 0) : 1'b1;
                if (req) begin
                    chk("almost_empty_req", {31'h0, bus.almost_empty}, 32'h0);
                    cnt++;
                end
                drive_now(req, 1'b0);
            end
            idle(max_gap == 0 ? 0 : $urandom_range(0, max_gap));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_now(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_pixel", {8'h0, bus.pixel_data}, 32'h0);
        chk("rst_almost_empty", {31'h0, bus.almost_empty}, 32'h1);
        chk("rst_underrun", {31'h0, bus.underrun}, 32'h0);
        chk("rst_fb_rd", {31'h0, bus.fb_rd}, 32'h0);
        chk("rst_fb_addr", {17'h0, bus.fb_addr}, 32'h0);
        reset = 1'b0;
        m_ox  = 0;
        m_oy  = 0;
        for (int i = 0; i < 16; i++) pal_m[i] = '0;
    endtask

    initial begin
        bit found;
        bus.frame_sync = 1'b0;
        bus.data_req   = 1'b0;
        bus.pal_we     = 1'b0;
        bus.pal_idx    = '0;
        bus.pal_data   = '0;
        for (int i = 0; i < TB_W * TB_H; i++) fb_m[i] = '0;

        do_reset();
        mon_en = 1'b1;

        // Uniform index 5 through a single palette entry.
        for (int i = 0; i < TB_W * TB_H; i++) fb_m[i] = 4'd5;
        pal_write(5, 24'h123456);
        start_frame();
        run_rows(1, 1'b0, 0);
        idle(4);
        chk("t1_underrun", {31'h0, bus.underrun}, 32'h0);

        // Line 0 ramps through all indices; grey palette.
        idle(200);
        for (int i = 0; i < TB_W * TB_H; i++) fb_m[i] = 4'($urandom_range(0, 15));
        for (int x = 0; x < TB_W; x++) fb_m[x] = 4'(x % 16);
        for (int i = 0; i < 16; i++) pal_write(i, {8'(i), 8'(i), 8'(i)});
        start_frame();
        run_rows(4, 1'b0, 0);

        // Full random frame with sparse requests and row gaps.
        idle(200);
        for (int i = 0; i < TB_W * TB_H; i++) fb_m[i] = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) pal_write(i, 24'($urandom));
        fetch_cnt = 0;
        last_hits = 0;
        start_frame();
        run_rows(OUT_H, 1'b1, 30);
        idle(50);
        chk("frame_fetches", 32'(fetch_cnt), 32'(TB_H));
        chk("frame_last_addr_hits", 32'(last_hits), 32'd1);
        chk("frame_underrun", {31'h0, bus.underrun}, 32'h0);

        // Abort the line-5 fetch midway with frame_sync.
        idle(20);
        start_frame();
        run_rows(16, 1'b0, 0);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.fb_rd === 1'b1 && bus.fb_addr == 15'(5 * TB_W + 80)) begin
                found = 1'b1;
                break;
            end
            drive_now(1'b1, 1'b0);
        end
        chk("abort_reached_fx80", {31'h0, found}, 32'h1);
        drive_now(1'b0, 1'b1);
        for (int n = 0; n < 170; n++) begin
            @(negedge clk);
            if (n == 0) begin
                chk("abort_fb_rd", {31'h0, bus.fb_rd}, 32'h1);
                chk("abort_fb_addr", {17'h0, bus.fb_addr}, 32'h0);
            end
            if (n == 161) chk("abort_empty_before", {31'h0, bus.almost_empty}, 32'h1);
            if (n == 162) chk("abort_empty_after", {31'h0, bus.almost_empty}, 32'h0);
            drive_now(1'b0, 1'b0);
        end
        run_rows(8, 1'b1, 10);
        chk("abort_underrun", {31'h0, bus.underrun}, 32'h0);

        // Request straight after frame_sync, before any line is fetched.
        idle(200);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        void'(exp_q.pop_back());
        exp_q.push_back(24'hFF00FF);
        @(negedge clk);
        chk("under_flag_set", {31'h0, bus.underrun}, 32'h1);
        chk("under_almost_empty", {31'h0, bus.almost_empty}, 32'h1);
        drive_now(1'b0, 1'b0);
        idle(200);
        chk("under_sticky", {31'h0, bus.underrun}, 32'h1);
        chk("under_bank_ready", {31'h0, bus.almost_empty}, 32'h0);
        cycle(1'b1, 1'b0);
        idle(4);

        mon_en = 1'b0;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
